prpg_seq_ctrl: RTL and testbench

- Sequencing controller for the W-bit LFSR pattern generator (PRPG).
- On a start request it seeds the PRPG and runs it for a programmed number of patterns, forwarding each pattern downstream with a valid strobe.
- While running it measures the sequence period (cycles until the seed recurs) and detects LFSR lock-up (all-zero state).
- Sits between the test/host logic and the PRPG datapath; the PRPG itself stays external.

---
 rtl/prpg_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_prpg_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prpg_seq_ctrl.sv
// ============================================================================
// Module   : prpg_seq_ctrl
// Brief    : Seeds and runs an external W-bit LFSR pattern generator for a
//            programmed pattern count, forwarding patterns with a valid
//            strobe while measuring the sequence period and detecting the
//            all-zero lock-up state.
//            Optional macro PRPG_SEQ_CTRL_AUTORESEED_EN: on lock-up, reseed
//            and continue (up to 3 times per run) instead of aborting.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prpg_seq_ctrl #(
    parameter int W     = 4,
    parameter int CNT_W = 8,
    parameter int PER_W = W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [W-1:0]     seed,
    input  logic [CNT_W-1:0] num_pat,
    output logic             prpg_load,
    output logic [W-1:0]     prpg_seed,
    output logic             prpg_en,
    input  logic [W-1:0]     prpg_seq,
    output logic             pat_valid,
    output logic [W-1:0]     pat_data,
    output logic             busy,
    output logic             done,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             lockup_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [PER_W-1:0] c_PER_ONE = PER_W'(1);
    localparam logic [PER_W-1:0] c_PER_MAX = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [W-1:0]     r_seed;
    logic [CNT_W-1:0] r_num_pat;
    logic [CNT_W-1:0] r_pat_cnt;
    logic [PER_W-1:0] r_per_cnt;
    logic             w_accept;
    logic             w_lockup;
    logic             w_last;
    logic             w_reseed_ok;
    logic             w_recur;

    assign w_accept = (r_state == c_IDLE) && start;
    assign w_lockup = (prpg_seq == '0);
    assign w_last   = (r_pat_cnt == (r_num_pat - c_CNT_ONE));
    assign w_recur  = (r_per_cnt != '0) && (prpg_seq == r_seed) && !period_valid;

`ifdef PRPG_SEQ_CTRL_AUTORESEED_EN
    logic [1:0] r_reseed_cnt;

    assign w_reseed_ok = (r_reseed_cnt != 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reseed_cnt <= 2'd0;
        end else if (w_accept) begin
            r_reseed_cnt <= 2'd0;
        end else if ((r_state == c_RUN) && w_lockup && w_reseed_ok) begin
            r_reseed_cnt <= r_reseed_cnt + 2'd1;
        end
    end
`else
    assign w_reseed_ok = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; lock-up outranks stop, which outranks the count
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = (num_pat != '0) ? c_LOAD : c_DONE;
                end
            end
            c_LOAD: w_next_state = c_RUN;
            c_RUN: begin
                if (w_lockup) begin
                    w_next_state = w_reseed_ok ? c_LOAD : c_DONE;
                end else if (stop || w_last) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        prpg_load = 1'b0;
        prpg_seed = '0;
        prpg_en   = 1'b0;
        pat_valid = 1'b0;
        pat_data  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            c_LOAD: begin
                prpg_load = 1'b1;
                prpg_seed = r_seed;
                busy      = 1'b1;
            end
            c_RUN: begin
                prpg_en   = 1'b1;
                pat_valid = !w_lockup;
                pat_data  = prpg_seq;
                busy      = 1'b1;
            end
            c_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Run bookkeeping: seed/count latch, pattern and period counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed       <= '0;
            r_num_pat    <= '0;
            r_pat_cnt    <= '0;
            r_per_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            lockup_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        // all-zero seed would lock the LFSR, substitute all-ones
                        r_seed       <= (seed == '0) ? '1 : seed;
                        r_num_pat    <= num_pat;
                        r_pat_cnt    <= '0;
                        r_per_cnt    <= '0;
                        period       <= '0;
                        period_valid <= 1'b0;
                        lockup_err   <= 1'b0;
                    end
                end
                c_LOAD: r_per_cnt <= '0;
                c_RUN: begin
                    if (r_per_cnt != c_PER_MAX) begin
                        r_per_cnt <= r_per_cnt + c_PER_ONE;
                    end
                    if (w_lockup) begin
                        lockup_err <= 1'b1;
                    end else begin
                        r_pat_cnt <= r_pat_cnt + c_CNT_ONE;
                        if (w_recur) begin
                            period       <= r_per_cnt;
                            period_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prpg_seq_ctrl.sv
// ============================================================================
// Module   : tb_prpg_seq_ctrl
// Brief    : Self-checking bench for prpg_seq_ctrl with a 4-bit maximal LFSR
//            stub and a sequence-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prpg_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] seed;
    logic [7:0] num_pat;
    logic       prpg_load;
    logic [3:0] prpg_seed;
    logic       prpg_en;
    logic [3:0] prpg_seq;
    logic       pat_valid;
    logic [3:0] pat_data;
    logic       busy;
    logic       done;
    logic [4:0] period;
    logic       period_valid;
    logic       lockup_err;

    int total = 0;
    int bad   = 0;

    prpg_seq_ctrl #(.W(4), .CNT_W(8), .PER_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .seed         (seed),
        .num_pat      (num_pat),
        .prpg_load    (prpg_load),
        .prpg_seed    (prpg_seed),
        .prpg_en      (prpg_en),
        .prpg_seq     (prpg_seq),
        .pat_valid    (pat_valid),
        .pat_data     (pat_data),
        .busy         (busy),
        .done         (done),
        .period       (period),
        .period_valid (period_valid),
        .lockup_err   (lockup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PRPG stub: x^4+x^3+1, with a forced all-zero injection hook
    logic [3:0] lfsr;
    logic       zero_now;
    always @(posedge clk) begin
        if (prpg_load)    lfsr <= prpg_seed;
        else if (prpg_en) lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
    assign prpg_seq = zero_now ? 4'h0 : lfsr;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model results
    logic [3:0] exp_q[$];
    int         exp_period, exp_pv, exp_lock, exp_loads, exp_runs;

    task automatic model(input logic [3:0] sd, input int np, input int zat, input int sat);
        logic [3:0] s, cur, v;
        int k, r, reseeds;
        bit fin;
        exp_q.delete();
        exp_period = 0; exp_pv = 0; exp_lock = 0; exp_loads = 0; exp_runs = 0;
        s = (sd == 4'h0) ? 4'hF : sd;
        if (np == 0) return;
        exp_loads = 1; cur = s; k = 0; r = 0; reseeds = 0; fin = 0;
        while (!fin) begin
            r++; exp_runs++;
            v = (r == zat) ? 4'h0 : cur;
            if (v == 4'h0) begin
                exp_lock = 1;
`ifdef PRPG_SEQ_CTRL_AUTORESEED_EN
                if (reseeds < 3) begin
                    reseeds++; exp_loads++; cur = s; k = 0;
                    continue;
                end
`endif
                fin = 1;
            end else begin
                if (k != 0 && v == s && exp_pv == 0) begin
                    exp_period = k; exp_pv = 1;
                end
                exp_q.push_back(v);
                if (r == sat || exp_q.size() == np) fin = 1;
                cur = lfsr_next(cur);
                if (k < 31) k++;
            end
        end
    endtask

    logic [3:0] got[$];
    int         loads, busy_cnt, done_cyc, run_idx;
    logic [3:0] ld_seed;

    task automatic do_run(input logic [3:0] sd, input int np, input int zat,
                          input int sat, input bit poke_start);
        model(sd, np, zat, sat);
        got.delete(); loads = 0; busy_cnt = 0; done_cyc = -1; run_idx = 0; ld_seed = 4'h0;
        @(negedge clk);
        start = 1'b1; seed = sd; num_pat = np[7:0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 400 && done_cyc < 0; c++) begin
            if (prpg_en) run_idx++;
            zero_now = prpg_en && (run_idx == zat);
            stop     = prpg_en && (run_idx == sat);
            start    = poke_start && prpg_en && (run_idx == 3);
            #1;
            if (pat_valid) got.push_back(pat_data);
            if (prpg_load) begin loads++; ld_seed = prpg_seed; end
            if (busy) busy_cnt++;
            if (done) done_cyc = c;
            @(posedge clk); #1;
        end
        zero_now = 1'b0; stop = 1'b0; start = 1'b0;
        check("done_seen", (done_cyc >= 0), 1);
        check("done_cycle", done_cyc, 1 + exp_loads + exp_runs);
        check("n_patterns", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("pat[%0d]", i), got[i], exp_q[i]);
        check("n_loads", loads, exp_loads);
        check("busy_cycles", busy_cnt, exp_loads + exp_runs);
        check("period", period, exp_period);
        check("period_valid", period_valid, exp_pv);
        check("lockup_err", lockup_err, exp_lock);
        @(posedge clk); #1;
        check("idle_after_done", busy, 0);
    endtask

    logic [3:0] lfsr_hold;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; seed = 4'h0; num_pat = 8'h0;
        zero_now = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_load", prpg_load, 0);
        check("rst_en", prpg_en, 0);
        check("rst_valid", pat_valid, 0);
        check("rst_period", period, 0);
        check("rst_pv", period_valid, 0);
        check("rst_lock", lockup_err, 0);
        check("rst_seed_out", prpg_seed, 0);
        @(negedge clk); rst_n = 1'b1;

        // Full-period run
        do_run(4'hF, 20, 0, 0, 1'b0);
        if (got.size() > 0) check("first_pat", got[0], 4'hF);
        check("period_15", period, 15);
        // Zero seed replaced by all-ones
        do_run(4'h0, 3, 0, 0, 1'b0);
        check("zero_seed_load", ld_seed, 4'hF);
        // Zero pattern count
        do_run(4'h7, 0, 0, 0, 1'b0);
        check("np0_done_cyc", done_cyc, 1);
        // Lock-up on 5th RUN cycle
        do_run(4'hF, 20, 5, 0, 1'b0);
        // Stop on 6th RUN cycle, stray start during RUN
        do_run(4'hA, 50, 0, 6, 1'b1);
        check("stop_npat", got.size(), 6);

        // Asynchronous reset on 8th RUN cycle
        @(negedge clk);
        start = 1'b1; seed = 4'h5; num_pat = 8'd20;
        @(posedge clk); #1;
        start = 1'b0; run_idx = 0;
        for (int c = 0; c < 50; c++) begin
            if (prpg_en) run_idx++;
            if (run_idx == 8) break;
            @(posedge clk); #1;
        end
        check("reach_run8", run_idx, 8);
        lfsr_hold = lfsr;
        rst_n = 1'b0; #1;
        check("arst_busy", busy, 0);
        check("arst_valid", pat_valid, 0);
        check("arst_en", prpg_en, 0);
        check("arst_pv", period_valid, 0);
        check("arst_load", prpg_load, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_idle", busy, 0);
        check("arst_prpg_kept", lfsr, lfsr_hold);
        do_run(4'h9, 10, 0, 0, 1'b0);

        // Randomized runs
        for (int t = 0; t < 10; t++) begin
            logic [3:0] rs;
            int rn, rz, rt;
            rs = 4'($urandom_range(0, 15));
            rn = $urandom_range(0, 40);
            rz = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
            rt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
            do_run(rs, rn, rz, rt, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
